// File: rtl/sys_arr.sv
// +----------------------------------------------------------------------------+
// | sys_arr: weight-stationary N x N systolic array of signed 8-bit MAC PEs.  |
// | Optional: SYSARR_SATURATE_EN clamps each accumulate instead of wrapping.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sys_arr #(
  parameter int width_height = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       active,
  input  logic [8*width_height-1:0]  datain,
  input  logic [8*width_height-1:0]  win,
  input  logic [16*width_height-1:0] sumin,
  input  logic [width_height-1:0]    wwrite,
  output logic [16*width_height-1:0] maccout,
  output logic [8*width_height-1:0]  wout,
  output logic [width_height-1:0]    wwriteout,
  output logic [width_height-1:0]    activeout,
  output logic [8*width_height-1:0]  dataout
);

  localparam int N = width_height;

  logic [7:0]   pe_w    [N][N];
  logic [7:0]   pe_data [N][N];
  logic [15:0]  pe_sum  [N][N];
  logic         pe_act  [N][N];
  logic [N-1:0] wwrite_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wwrite_q <= '0;
    else       wwrite_q <= wwrite;
  end
  assign wwriteout = wwrite_q;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [7:0]  data_in, w_in, data_q, weight_q, weight_d;
      logic [15:0] sum_above, prod, sum_next, sum_q, sum_d;
      logic        act_in, act_q;

      if (c == 0) begin : g_data_edge
        assign data_in = datain[8*r +: 8];
      end else begin : g_data_pe
        assign data_in = pe_data[r][c-1];
      end

      if (r == 0) begin : g_top_edge
        assign w_in      = win[8*c +: 8];
        assign sum_above = sumin[16*c +: 16];
      end else begin : g_top_pe
        assign w_in      = pe_w[r-1][c];
        assign sum_above = pe_sum[r-1][c];
      end

      // Active walks down column 0, then right along each row.
      if (c > 0) begin : g_act_left
        assign act_in = pe_act[r][c-1];
      end else if (r > 0) begin : g_act_up
        assign act_in = pe_act[r-1][0];
      end else begin : g_act_port
        assign act_in = active;
      end

      assign prod = {{8{data_in[7]}}, data_in} * {{8{weight_q[7]}}, weight_q};

`ifdef SYSARR_SATURATE_EN
      logic [16:0] wide;
      assign wide = {sum_above[15], sum_above} + {prod[15], prod};
      always_comb begin
        sum_next = wide[15:0];
        if (wide[16] != wide[15]) sum_next = wide[16] ? 16'h8000 : 16'h7FFF;
      end
`else
      assign sum_next = sum_above + prod;
`endif

      always_comb begin
        weight_d = wwrite[c] ? w_in : weight_q;
        sum_d    = act_in ? sum_next : sum_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q   <= '0;
          weight_q <= '0;
          sum_q    <= '0;
          act_q    <= 1'b0;
        end else begin
          data_q   <= data_in;
          weight_q <= weight_d;
          sum_q    <= sum_d;
          act_q    <= act_in;
        end
      end

      assign pe_w[r][c]    = weight_q;
      assign pe_data[r][c] = data_q;
      assign pe_sum[r][c]  = sum_q;
      assign pe_act[r][c]  = act_q;
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_col_out
    assign maccout[16*c +: 16] = pe_sum[N-1][c];
    assign wout[8*c +: 8]      = pe_w[N-1][c];
    assign activeout[c]        = pe_act[N-1][c];
  end

  for (genvar r = 0; r < N; r++) begin : g_row_out
    assign dataout[8*r +: 8] = pe_data[r][N-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_arr.sv
// +----------------------------------------------------------------------------+
// | tb_sys_arr: scoreboard bench for the N=2 systolic array.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sys_arr;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           active;
  logic [8*N-1:0] datain, win, wout, dataout;
  logic [16*N-1:0] sumin, maccout;
  logic [N-1:0]   wwrite, wwriteout, activeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          col;
    logic [15:0] val;
    int          due;
  } exp_t;
  exp_t expq[$];

  logic [7:0]  W  [N][N];
  logic [7:0]  vx [16][N];
  logic [15:0] vs [16][N];
  bit          va [16];
  int          nvec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sys_arr #(.width_height(N)) dut (
    .clk(clk), .reset(reset), .active(active), .datain(datain), .win(win),
    .sumin(sumin), .wwrite(wwrite), .maccout(maccout), .wout(wout),
    .wwriteout(wwriteout), .activeout(activeout), .dataout(dataout)
  );

  // Column result: sumin plus every row's product, accumulated top to bottom.
  function automatic logic [15:0] model_col(int k, int c);
    int acc;
    acc = int'($signed(vs[k][c]));
    for (int r = 0; r < N; r++) begin
      acc = acc + int'($signed(vx[k][r])) * int'($signed(W[r][c]));
`ifdef SYSARR_SATURATE_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
`endif
    end
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < N; c++) begin
        if (activeout[c]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < expq.size(); i++) begin
            if (idx < 0 && expq[i].col == c) idx = i;
          end
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_result col%0d: maccout=%h, none required", c, maccout[16*c +: 16]);
          end else begin
            if (maccout[16*c +: 16] !== expq[idx].val || cyc != expq[idx].due) begin
              errors++;
              $display("FAIL result col%0d: got %h at cycle %0d, required %h at cycle %0d",
                       c, maccout[16*c +: 16], cyc, expq[idx].val, expq[idx].due);
            end
            expq.delete(idx);
          end
        end
      end
    end
  end

  task automatic load_word(input logic [8*N-1:0] w);
    @(negedge clk);
    win    = w;
    wwrite = '1;
    for (int c = 0; c < N; c++) begin
      for (int r = N-1; r > 0; r--) W[r][c] = W[r-1][c];
      W[0][c] = w[8*c +: 8];
    end
  endtask

  task automatic load_end();
    @(negedge clk);
    wwrite = '0;
  endtask

  // Drives nvec vectors with the row/column skew and pushes their expectations.
  task automatic run_vectors();
    for (int t = 0; t < nvec + N; t++) begin
      @(negedge clk);
      active = (t < nvec) ? va[t] : 1'b0;
      for (int r = 0; r < N; r++)
        datain[8*r +: 8] = (t - r >= 0 && t - r < nvec) ? vx[t-r][r] : 8'h00;
      for (int c = 0; c < N; c++)
        sumin[16*c +: 16] = (t - c >= 0 && t - c < nvec) ? vs[t-c][c] : 16'h0000;
      if (t < nvec && va[t]) begin
        for (int c = 0; c < N; c++) begin
          exp_t e;
          e.col = c;
          e.val = model_col(t, c);
          e.due = cyc + N + c;
          expq.push_back(e);
        end
      end
    end
    repeat (N + 2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks += 5;
    if (maccout !== '0)   begin errors++; $display("FAIL %s maccout: got %h required 0", tag, maccout); end
    if (wout !== '0)      begin errors++; $display("FAIL %s wout: got %h required 0", tag, wout); end
    if (wwriteout !== '0) begin errors++; $display("FAIL %s wwriteout: got %b required 0", tag, wwriteout); end
    if (activeout !== '0) begin errors++; $display("FAIL %s activeout: got %b required 0", tag, activeout); end
    if (dataout !== '0)   begin errors++; $display("FAIL %s dataout: got %h required 0", tag, dataout); end
  endtask

  task automatic test_reset();
    reset = 1'b1; active = 1'b0; datain = '0; win = '0; sumin = '0; wwrite = '0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) W[r][c] = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_weight_load();
    load_word(16'h0302);
    load_word(16'h0504);
    @(negedge clk);
    checks += 2;
    if (wout !== 16'h0302) begin errors++; $display("FAIL wload wout: got %h required 0302", wout); end
    if (wwriteout !== 2'b11) begin errors++; $display("FAIL wload wwriteout: got %b required 11", wwriteout); end
    wwrite = '0;
  endtask

  task automatic test_matmul();
    nvec = 1; va[0] = 1'b1;
    vx[0][0] = 8'd1; vx[0][1] = 8'd2; vs[0][0] = 16'd0; vs[0][1] = 16'd0;
    run_vectors();
    checks++;
    if (maccout !== {16'd11, 16'd8}) begin
      errors++; $display("FAIL matmul final: got %h required %h", maccout, {16'd11, 16'd8});
    end
  endtask

  task automatic test_sumin();
    nvec = 1; va[0] = 1'b1;
    vx[0][0] = 8'd1; vx[0][1] = 8'd2; vs[0][0] = 16'h000A; vs[0][1] = 16'h0001;
    run_vectors();
    checks++;
    if (maccout !== {16'd12, 16'd18}) begin
      errors++; $display("FAIL sumin final: got %h required %h", maccout, {16'd12, 16'd18});
    end
  endtask

  task automatic test_hold();
    logic [16*N-1:0] held;
    logic [8*N-1:0]  hist[$];
    held = maccout;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t > 0) begin
        checks += 2;
        if (maccout !== held) begin errors++; $display("FAIL hold maccout: got %h required %h", maccout, held); end
        if (activeout !== '0) begin errors++; $display("FAIL hold activeout: got %b required 0", activeout); end
      end
      if (hist.size() >= N) begin
        checks++;
        if (dataout !== hist[hist.size()-N]) begin
          errors++; $display("FAIL hold dataout: got %h required %h", dataout, hist[hist.size()-N]);
        end
      end
      active = 1'b0;
      datain = 16'($urandom);
      sumin  = 32'($urandom);
      hist.push_back(datain);
    end
    @(negedge clk);
    datain = '0; sumin = '0;
  endtask

  task automatic test_overflow();
    logic [15:0] want;
    load_word(16'h7F7F);
    load_word(16'h7F7F);
    load_end();
    nvec = 1; va[0] = 1'b1;
    vx[0][0] = 8'd127; vx[0][1] = 8'd127; vs[0][0] = 16'd16129; vs[0][1] = 16'd0;
    run_vectors();
`ifdef SYSARR_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'hBD03;
`endif
    checks += 2;
    if (maccout[15:0] !== want) begin errors++; $display("FAIL overflow col0: got %h required %h", maccout[15:0], want); end
    if (maccout[31:16] !== 16'h7E02) begin errors++; $display("FAIL overflow col1: got %h required 7e02", maccout[31:16]); end
  endtask

  task automatic test_back_to_back();
    load_word(16'($urandom));
    load_word(16'($urandom));
    load_end();
    nvec = 8;
    for (int k = 0; k < nvec; k++) begin
      va[k] = 1'b1;
      for (int r = 0; r < N; r++) vx[k][r] = 8'($urandom);
      for (int c = 0; c < N; c++) vs[k][c] = 16'($urandom);
    end
    run_vectors();
  endtask

  task automatic test_reset_midrun();
    load_word(16'h7F81);
    load_word(16'h12F4);
    load_end();
    @(negedge clk);
    active = 1'b1; datain = 16'h0505; win = 16'hA5C3; wwrite = '1; sumin = 32'h0003_0002;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    active = 1'b0; wwrite = '0; datain = '0; sumin = '0; win = '0;
    expq.delete();
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) W[r][c] = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (N + 2) @(negedge clk);
    check_all_zero("post_reset");
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_matmul();
    test_sumin();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
